vga_filter_controller: RTL and testbench
========================================

Name: vga_filter_controller

Overview:
- Frame-synchronous controller for the VGA filter pipeline (threshold -> brightness -> ADSR).
- Debounces the filter-enable keys and clamps the detector BPM into the 8-bit filter range.
- Converts asynchronous beat detections into one frame-aligned ADSR beat_trigger plus a decaying pulse_amplitude.
- All filter configuration changes only at a fixed blanking line, so no frame is rendered with mixed settings. Sits in the pix_clk domain between the BPM/beat detectors and the filter stages.

Parameters:
- DEBOUNCE_CYCLES, 250000, cycles a key must be stable before its state is accepted (10 ms at 25 MHz).
- V_TRIGGER, 480, vcount line on which config is applied (first vertical blanking line).
- MIN_BPM, 40, lower clamp for BPM_estimate.
- MAX_BPM, 200, upper clamp for BPM_estimate.
- DEFAULT_BPM, 100, BPM_estimate after reset and while no valid BPM has been seen.
- DECAY_STEP, 16, amount pulse_amplitude falls per frame without a beat.
- ENABLE_RESET, 3'b000, reset value of {adsr_en, bright_en, thresh_en}.
- HOLDOFF_FRAMES, 8, minimum frames between triggers (optional feature only).

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high
- hcount  in  10  horizontal counter from vga_sync
- vcount  in  10  vertical counter from vga_sync
- key_n  in  3  raw active-low keys {adsr, bright, thresh}; asynchronous
- bpm_val  in  16  BPM from energy detector; 0 = no estimate
- beat_detected  in  1  beat pulse; any width, rising edge counts
- thresh_en  out  1  threshold filter_enable
- bright_en  out  1  brightness filter_enable
- adsr_en  out  1  ADSR filter_enable
- BPM_estimate  out  8  clamped BPM for all filters
- beat_trigger  out  1  one-cycle ADSR trigger
- pulse_amplitude  out  8  ADSR pulse amplitude
- cfg_update  out  1  one-cycle strobe when outputs are refreshed

Behaviour:
- Reset values: enables = ENABLE_RESET; BPM_estimate = DEFAULT_BPM; beat_trigger = 0; pulse_amplitude = 0; cfg_update = 0. Reset also clears the beat-pending flag, all debouncers (stable state = released) and shadow registers.
- frame_start is a combinational condition: hcount == 0 && vcount == V_TRIGGER. Exactly one cycle per frame.
- All outputs are registered. They change on the clock edge that ends the frame_start cycle (latency 1); cfg_update is 1 for that one cycle.
- Key path, per key:
  - 2-flop synchronizer, then debounce counter.
  - When the synchronized value differs from the stable value, the counter increments; otherwise it clears.
  - When the count reaches DEBOUNCE_CYCLES-1, the stable value is updated and the counter clears.
  - A stable 1->0 transition (press) toggles that key's shadow enable bit. Release does nothing.
  - Shadow bits copy to the enable outputs only at frame_start.
  - Two presses of one key within a frame toggle twice, giving net no change.
- BPM path, sampled at frame_start:
  - bpm_val == 0: hold the previous value.
  - bpm_val < MIN_BPM: MIN_BPM.
  - bpm_val > MAX_BPM: MAX_BPM.
  - Otherwise bpm_val[7:0].
  - The comparison uses the full 16 bits.
- Beat FSM, states IDLE, PENDING, FIRE:
  - IDLE -> PENDING on a beat_detected rising edge (edge detect register).
  - PENDING -> FIRE at frame_start. FIRE lasts one cycle: beat_trigger = 1, pulse_amplitude = 255, then -> IDLE.
  - Multiple beats within one frame collapse to one trigger.
  - A rising edge on the frame_start cycle itself counts for that frame. IDLE goes directly to FIRE.
  - A rising edge during FIRE -> PENDING (next frame).
  - At frame_start without a trigger, pulse_amplitude -= DECAY_STEP, saturating at 0. Arithmetic is 9-bit, no underflow wrap.
- Reset asserted mid-frame: all state returns to reset values on the next edge; the pending beat is discarded.

Optional Feature:
- Macro: BEAT_HOLDOFF_EN
- When defined:
  - A 4-bit-or-wider frame counter counts frames since the last FIRE, saturating at HOLDOFF_FRAMES.
  - PENDING at frame_start fires only if the counter has reached HOLDOFF_FRAMES. Otherwise the pending beat is dropped (-> IDLE) and amplitude decays normally.
  - The counter resets to 0 on FIRE and to HOLDOFF_FRAMES on reset, so the first beat fires.
- When undefined: no counter; every pending beat fires at the next frame_start.

Test Plan:
- Reset then idle 2 frames -> enables 000, BPM_estimate 100, pulse_amplitude 0, cfg_update exactly once per frame, 1 cycle after hcount=0/vcount=480.
- DEBOUNCE_CYCLES=4; key_n[1] low for 10 cycles mid-frame -> bright_en stays 0 until the frame_start edge, then 1. Glitch low for 2 cycles -> no change.
- bpm_val = 0, 25, 120, 300, 0 on successive frames -> BPM_estimate 100, 40, 120, 200, 200.
- beat_detected pulses 3 times in one frame -> single beat_trigger at next frame_start, pulse_amplitude 255. Then no beats -> 239, 223, ..., 15, 0, 0.
- Beat rising edge on the frame_start cycle -> beat_trigger and cfg_update in the same next cycle. Reset asserted while PENDING -> no trigger at the following frame_start.
- BEAT_HOLDOFF_EN, HOLDOFF_FRAMES=8; beats every 3 frames -> triggers at frames 0, 9, 18; without the macro -> triggers at frames 0, 3, 6, ...

Source files
------------

// File: rtl/vga_filter_controller.sv
// vga_filter_controller
//   Frame-synchronous controller for the VGA filter chain
//   (threshold -> brightness -> ADSR), clocked in the pixel-clock domain.
//   It debounces the three filter-enable keys and clamps the detector BPM
//   into the 8-bit filter range. It also turns asynchronous beat pulses into
//   one frame-aligned ADSR trigger plus a decaying pulse amplitude.
//   All configuration outputs are refreshed together on the edge that ends
//   the frame_start cycle (hcount == 0, vcount == V_TRIGGER), so a rendered
//   frame never sees mixed settings.
//
// Ports
//   clk              pixel clock
//   reset            synchronous, active-high
//   hcount, vcount   raster counters from vga_sync
//   key_n[2:0]       raw active-low keys {adsr, bright, thresh}, asynchronous
//   bpm_val[15:0]    BPM from the energy detector, 0 = no estimate
//   beat_detected    beat pulse of any width; its rising edge counts
//   thresh_en        threshold filter enable
//   bright_en        brightness filter enable
//   adsr_en          ADSR filter enable
//   BPM_estimate     clamped BPM shared by all filters
//   beat_trigger     one-cycle ADSR trigger
//   pulse_amplitude  ADSR pulse amplitude
//   cfg_update       one-cycle strobe marking the output refresh
//
// Build option
//   BEAT_HOLDOFF_EN  when defined, a pending beat fires only if at least
//                    HOLDOFF_FRAMES frames have passed since the last trigger.
//                    Otherwise the beat is dropped.

module vga_filter_controller #(
  parameter int         DEBOUNCE_CYCLES = 250000,
  parameter int         V_TRIGGER       = 480,
  parameter int         MIN_BPM         = 40,
  parameter int         MAX_BPM         = 200,
  parameter int         DEFAULT_BPM     = 100,
  parameter int         DECAY_STEP      = 16,
  parameter logic [2:0] ENABLE_RESET    = 3'b000
`ifdef BEAT_HOLDOFF_EN
  , parameter int       HOLDOFF_FRAMES  = 8
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  input  logic [2:0]  key_n,
  input  logic [15:0] bpm_val,
  input  logic        beat_detected,
  output logic        thresh_en,
  output logic        bright_en,
  output logic        adsr_en,
  output logic [7:0]  BPM_estimate,
  output logic        beat_trigger,
  output logic [7:0]  pulse_amplitude,
  output logic        cfg_update
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] PENDING = 2'd1;
  localparam logic [1:0] FIRE    = 2'd2;

  function automatic logic [7:0] clamp_bpm(input logic [15:0] v, input logic [7:0] prev);
    if (v == 16'd0)                 return prev;
    else if (v < 16'(MIN_BPM))      return 8'(MIN_BPM);
    else if (v > 16'(MAX_BPM))      return 8'(MAX_BPM);
    else                            return v[7:0];
  endfunction

  // Decrement in 9-bit signed arithmetic so a step past zero is seen as
  // negative and saturates instead of wrapping.
  function automatic logic [7:0] decay_amp(input logic [7:0] a);
    logic signed [8:0] d;
    d = $signed({1'b0, a}) - $signed(9'(DECAY_STEP));
    return (d < 0) ? 8'd0 : d[7:0];
  endfunction

  logic              frame_start;
  logic [2:0]        sync_p0, sync_p1;
  logic [2:0]        stable;
  logic [CW-1:0]     db_cnt [3];
  logic [2:0]        shadow;
  logic [2:0]        en_q;
  logic              beat_p0;
  logic              beat_rise;
  logic [1:0]        state, state_nxt;
  logic              hold_ok;
  logic              fire_now;

  assign frame_start = (hcount == 10'd0) && (vcount == 10'(V_TRIGGER));
  assign {adsr_en, bright_en, thresh_en} = en_q;

  // Stage p0/p1: two-flop synchronizer on the raw keys (released = 1)
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= 3'b111;
      sync_p1 <= 3'b111;
    end else begin
      sync_p0 <= key_n;
      sync_p1 <= sync_p0;
    end
  end

  // Stage p2: debounce, press detection and shadow enable toggling.
  // A level is accepted after DEBOUNCE_CYCLES consecutive differing cycles.
  // Only an accepted press (1 -> 0) toggles the shadow bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      stable <= 3'b111;
      shadow <= ENABLE_RESET;
      for (int k = 0; k < 3; k++) db_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (sync_p1[k] != stable[k]) begin
          if (db_cnt[k] == CW'(DEBOUNCE_CYCLES - 1)) begin
            stable[k] <= sync_p1[k];
            db_cnt[k] <= '0;
            if (!sync_p1[k]) shadow[k] <= ~shadow[k];
          end else begin
            db_cnt[k] <= db_cnt[k] + CW'(1);
          end
        end else begin
          db_cnt[k] <= '0;
        end
      end
    end
  end

  // Beat edge detect
  always_ff @(posedge clk) begin
    if (reset) beat_p0 <= 1'b0;
    else       beat_p0 <= beat_detected;
  end

  assign beat_rise = beat_detected & ~beat_p0;

`ifdef BEAT_HOLDOFF_EN
  localparam int HW = ($clog2(HOLDOFF_FRAMES + 1) > 4) ? $clog2(HOLDOFF_FRAMES + 1) : 4;
  logic [HW-1:0] hold_cnt;

  // Frames since the last trigger, saturating. Reset loads the ceiling so
  // that the first beat after reset is allowed to fire.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt <= HW'(HOLDOFF_FRAMES);
    end else if (frame_start) begin
      if (fire_now)                             hold_cnt <= '0;
      else if (hold_cnt < HW'(HOLDOFF_FRAMES))  hold_cnt <= hold_cnt + HW'(1);
    end
  end

  assign hold_ok = (hold_cnt >= HW'(HOLDOFF_FRAMES));
`else
  assign hold_ok = 1'b1;
`endif

  // A rise on the frame_start cycle itself belongs to this frame, so IDLE can
  // go straight to FIRE.
  assign fire_now = frame_start && hold_ok &&
                    ((state == PENDING) || ((state == IDLE) && beat_rise));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (beat_rise) state_nxt = frame_start ? (hold_ok ? FIRE : IDLE) : PENDING;
      PENDING: if (frame_start) state_nxt = hold_ok ? FIRE : IDLE;
      FIRE:    state_nxt = beat_rise ? PENDING : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output stage: every configuration output refreshes on the frame_start edge
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      en_q            <= ENABLE_RESET;
      BPM_estimate    <= 8'(DEFAULT_BPM);
      beat_trigger    <= 1'b0;
      pulse_amplitude <= 8'd0;
      cfg_update      <= 1'b0;
    end else begin
      state        <= state_nxt;
      cfg_update   <= frame_start;
      beat_trigger <= fire_now;
      if (frame_start) begin
        en_q            <= shadow;
        BPM_estimate    <= clamp_bpm(bpm_val, BPM_estimate);
        pulse_amplitude <= fire_now ? 8'd255 : decay_amp(pulse_amplitude);
      end
    end
  end

endmodule

// File: tb/tb_vga_filter_controller.sv
// tb_vga_filter_controller
//   Randomized bench for vga_filter_controller. A frame-level reference
//   model predicts every configuration refresh. Predictions are queued at the
//   frame_start cycle, and a monitor checks them whenever cfg_update appears.
//   The raster is compressed to 16 pixels x 12 lines around line 480.

module tb_vga_filter_controller;

  localparam int DB    = 4;
  localparam int VT    = 480;
  localparam int HP    = 16;
  localparam int LINES = 12;
  localparam int FL    = HP * LINES;
  localparam int NF    = 60;
  localparam int DSTEP = 16;
  localparam int HOLD  = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  hcount, vcount;
  logic [2:0]  key_n;
  logic [15:0] bpm_val;
  logic        beat_detected;
  logic        thresh_en, bright_en, adsr_en;
  logic [7:0]  BPM_estimate;
  logic        beat_trigger;
  logic [7:0]  pulse_amplitude;
  logic        cfg_update;

  vga_filter_controller #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount),
    .key_n(key_n), .bpm_val(bpm_val), .beat_detected(beat_detected),
    .thresh_en(thresh_en), .bright_en(bright_en), .adsr_en(adsr_en),
    .BPM_estimate(BPM_estimate), .beat_trigger(beat_trigger),
    .pulse_amplitude(pulse_amplitude), .cfg_update(cfg_update)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] en;
    logic [7:0] bpm;
    logic       trig;
    logic [7:0] amp;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model state (frame-level view of the rules)
  logic [2:0] m_shadow;
  int         m_bpm, m_amp, m_hold;
  bit         m_pend;
  bit         beat_prev;
  logic       beat_w [FL];
  logic [2:0] key_w  [FL];

  task automatic model_reset();
    m_shadow = 3'b000;
    m_bpm    = 100;
    m_amp    = 0;
    m_pend   = 0;
    m_hold   = HOLD;
  endtask

  task automatic model_frame(input bit rise);
    exp_t e;
    bit   fire;
    fire = m_pend || rise;
`ifdef BEAT_HOLDOFF_EN
    fire = fire && (m_hold >= HOLD);
`endif
    if (bpm_val != 16'd0)
      m_bpm = (bpm_val < 16'd40) ? 40 : (bpm_val > 16'd200) ? 200 : int'(bpm_val);
    m_amp = fire ? 255 : ((m_amp > DSTEP) ? m_amp - DSTEP : 0);
    if (fire) m_hold = 0;
    else if (m_hold < HOLD) m_hold++;
    m_pend = 0;
    e.en   = m_shadow;
    e.bpm  = 8'(m_bpm);
    e.trig = fire;
    e.amp  = 8'(m_amp);
    e.cyc  = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic plan_beats(input int f, input bit rst_frame);
    int n, s, w;
    for (int t = 0; t < FL; t++) begin
      beat_w[t] = 1'b0;
      key_w[t]  = 3'b111;
    end
    n = 0;
    if (f == 3) n = 3;
    else if (f >= 21 && !rst_frame && $urandom_range(1, 0) == 1) n = $urandom_range(3, 1);
    for (int i = 0; i < n; i++) begin
      s = 20 + 50 * i + $urandom_range(30, 0);
      w = $urandom_range(5, 1);
      for (int j = 0; j < w; j++) beat_w[s + j] = 1'b1;
    end
    if (f == 25 || f == 35) for (int j = 0; j < 3; j++) beat_w[j] = 1'b1;
    if (f == 26 || f == 40) for (int j = 1; j < 4; j++) beat_w[j] = 1'b1;
    if (rst_frame) for (int j = 50; j < 53; j++) beat_w[j] = 1'b1;
  endtask

  // Each event is a press (>= DB cycles low) or a glitch (<= DB-2 cycles low)
  // followed by a long release, all well clear of the next frame_start.
  task automatic add_key(input int k, input bit press, input int len, inout int t);
    for (int j = 0; j < len; j++) key_w[t + j][k] = 1'b0;
    t += len + 8;
    if (press) m_shadow[k] = ~m_shadow[k];
  endtask

  task automatic plan_keys(input int f, input bit rst_frame);
    int t, n, k;
    bit press;
    t = 4;
    if (f == 2) begin
      add_key(1, 1'b1, 10, t);
      add_key(0, 1'b0, 2, t);
    end else if (f >= 4 && !rst_frame) begin
      n = $urandom_range(3, 0);
      for (int i = 0; i < n; i++) begin
        k = $urandom_range(2, 0);
        press = ($urandom_range(1, 0) == 1);
        add_key(k, press, press ? $urandom_range(10, DB) : $urandom_range(DB - 2, 1), t);
      end
    end
  endtask

  function automatic logic [15:0] next_bpm(input int f);
    logic [15:0] tbl [14];
    logic [15:0] dir [6];
    tbl = '{16'd0, 16'd1, 16'd39, 16'd40, 16'd41, 16'd100, 16'd199, 16'd200,
            16'd201, 16'd255, 16'd256, 16'd300, 16'd65535, 16'd0};
    dir = '{16'd0, 16'd0, 16'd25, 16'd120, 16'd300, 16'd0};
    if (f < 6) return dir[f];
    tbl[13] = 16'($urandom_range(400, 1));
    return tbl[$urandom_range(13, 0)];
  endfunction

  // Stimulus and model
  initial begin
    bit rst_frame, rise;
    reset = 1'b1; hcount = 10'd1; vcount = 10'd0;
    key_n = 3'b111; bpm_val = 16'd0; beat_detected = 1'b0;
    model_reset();
    beat_prev = 0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int f = 0; f < NF; f++) begin
      rst_frame = (f == 30 || f == 45);
      plan_beats(f, rst_frame);
      for (int t = 0; t < FL; t++) begin
        hcount        = 10'(t % HP);
        vcount        = 10'(VT - 6 + (6 + t / HP) % LINES);
        beat_detected = beat_w[t];
        key_n         = key_w[t];
        reset         = rst_frame && (t == 100);
        rise          = beat_w[t] && !beat_prev;
        beat_prev     = beat_w[t];
        if (t == 0) begin
          model_frame(rise);
          plan_keys(f, rst_frame);
        end else if (reset) begin
          model_reset();
        end else if (rise) begin
          m_pend = 1;
        end
        if (t == 1) bpm_val = next_bpm(f);
        @(posedge clk);
        #1;
      end
    end
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Monitor: pops a prediction on every cfg_update and checks that nothing
  // moves (and no trigger appears) between refreshes.
  initial begin
    bit         armed, after_rst;
    logic [2:0] l_en;
    logic [7:0] l_bpm, l_amp;
    exp_t       e;
    armed = 0; after_rst = 0;
    l_en = 3'b000; l_bpm = 8'd100; l_amp = 8'd0;
    forever begin
      @(negedge clk);
      if (reset) begin
        armed = 1;
        after_rst = 1;
      end else if (armed) begin
        if (after_rst) begin
          chk("reset_enables", {adsr_en, bright_en, thresh_en}, 3'b000);
          chk("reset_bpm", BPM_estimate, 100);
          chk("reset_amplitude", pulse_amplitude, 0);
          chk("reset_trigger", beat_trigger, 0);
          chk("reset_cfg_update", cfg_update, 0);
          l_en = 3'b000; l_bpm = 8'd100; l_amp = 8'd0;
          after_rst = 0;
        end else if (cfg_update) begin
          if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL cfg_unexpected: got cfg_update at cycle %0d, expected none", cyc);
          end else begin
            e = sb.pop_front();
            chk("cfg_latency", cyc, e.cyc);
            chk("enables", {adsr_en, bright_en, thresh_en}, e.en);
            chk("bpm_estimate", BPM_estimate, e.bpm);
            chk("beat_trigger", beat_trigger, e.trig);
            chk("pulse_amplitude", pulse_amplitude, e.amp);
            l_en = e.en; l_bpm = e.bpm; l_amp = e.amp;
          end
        end else begin
          chk("steady_outputs", {adsr_en, bright_en, thresh_en, BPM_estimate, pulse_amplitude, beat_trigger},
              {l_en, l_bpm, l_amp, 1'b0});
        end
      end
    end
  end

endmodule
